// File: rtl/ads_pkg.sv
// Shared definitions for the ADS conversion controller.
//   - Default values for the controller parameters.
//   - FSM state encoding.
//   - Counter width helper.
package ads_pkg;

    localparam int unsigned AdsDataW   = 16;
    localparam int unsigned AdsSclkHalf = 2;
    localparam int unsigned AdsConvstW = 4;
    localparam int unsigned AdsTmoCyc  = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitDrdy,
        StShift,
        StDone
    } ads_state_e;

    // Bits needed to hold any value 0..max_val (at least one bit).
    function automatic int unsigned ads_cnt_w(input int unsigned max_val);
        int unsigned w;
        w = 1;
        if (max_val >= 2) begin
            w = $clog2(max_val + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/ads_conv_ctrl_if.sv
// Pin-level bus between the conversion controller and the ADS converter.
//   ads_convst  controller -> converter  conversion start pulse
//   ads_cs_n    controller -> converter  chip select, active low
//   ads_sclk    controller -> converter  serial clock, idle low
//   ads_drdy_n  converter -> controller  data ready, active low, asynchronous
//   ads_dout    converter -> controller  serial data, MSB first
// master: controller side, slave: converter side.
interface ads_conv_ctrl_if;

    logic ads_convst;
    logic ads_cs_n;
    logic ads_sclk;
    logic ads_drdy_n;
    logic ads_dout;

    modport master (
        output ads_convst,
        output ads_cs_n,
        output ads_sclk,
        input  ads_drdy_n,
        input  ads_dout
    );

    modport slave (
        input  ads_convst,
        input  ads_cs_n,
        input  ads_sclk,
        output ads_drdy_n,
        output ads_dout
    );

endinterface

// File: rtl/ads_sync_2ff.sv
// Generic two-flop synchroniser for signals asynchronous to clk_i.
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset, both flops load ResetVal
//   d_i     asynchronous input
//   q_o     synchronised output, two cycles of latency
module ads_sync_2ff #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ads_conv_ctrl.sv
// Conversion and serial-readout controller for the ADS converter.
// On start_i it pulses CONVST, waits for DRDY (with timeout), clocks one
// DATA_W-bit sample in MSB-first over SCLK/DOUT and strobes it downstream.
//   sys_clk       ADS-domain clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   start_i       conversion request, level, sampled only while idle
//   ads           converter pin bus (master side)
//   sample_data   last completed sample
//   sample_valid  one-cycle strobe, sample_data is new
//   busy_o        high whenever the FSM is not idle
//   tmo_err       one-cycle strobe, DRDY did not arrive in time
module ads_conv_ctrl
    import ads_pkg::*;
#(
    parameter int unsigned DATA_W    = AdsDataW,
    parameter int unsigned SCLK_HALF = AdsSclkHalf,
    parameter int unsigned CONVST_W  = AdsConvstW,
    parameter int unsigned TMO_CYC   = AdsTmoCyc
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start_i,
    ads_conv_ctrl_if.master    ads,
    output logic [DATA_W-1:0]  sample_data,
    output logic               sample_valid,
    output logic               busy_o,
    output logic               tmo_err
);

    // One counter serves both the CONVST width and the DRDY timeout.
    localparam int unsigned CntW = ads_cnt_w((TMO_CYC > CONVST_W) ? TMO_CYC : CONVST_W);
    localparam int unsigned DivW = ads_cnt_w(SCLK_HALF);
    localparam int unsigned BitW = ads_cnt_w(DATA_W);

    localparam logic [CntW-1:0] ConvstLast = CntW'(CONVST_W - 1);
    localparam logic [CntW-1:0] TmoLast    = CntW'(TMO_CYC - 1);
    localparam logic [DivW-1:0] DivLast    = DivW'(SCLK_HALF - 1);
    localparam logic [BitW-1:0] BitsAll    = BitW'(DATA_W);

    ads_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [DivW-1:0]   div_q;
    logic [BitW-1:0]   bit_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              convst_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              valid_q;
    logic              busy_q;
    logic              tmo_q;

    logic drdy_n_sync;
    logic drdy_s;

    ads_sync_2ff #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_drdy_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (ads.ads_drdy_n),
        .q_o    (drdy_n_sync)
    );

    assign drdy_s = ~drdy_n_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            convst_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q  <= StConv;
                        convst_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                StConv: begin
                    if (cnt_q == ConvstLast) begin
                        state_q  <= StWaitDrdy;
                        convst_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitDrdy: begin
                    // DRDY is checked first so it wins over a coincident timeout.
                    if (drdy_s) begin
                        state_q <= StShift;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else if (cnt_q == TmoLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StShift: begin
                    if (div_q == DivLast) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // Rising edge: sample DOUT as presented during the low phase.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[DATA_W-2:0], ads.ads_dout};
                            bit_q   <= bit_q + BitW'(1);
                        end else begin
                            sclk_q <= 1'b0;
                            // Finish only on the falling edge after the last bit.
                            if (bit_q == BitsAll) begin
                                state_q <= StDone;
                                cs_n_q  <= 1'b1;
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ads.ads_convst = convst_q;
    assign ads.ads_cs_n   = cs_n_q;
    assign ads.ads_sclk   = sclk_q;
    assign sample_data    = data_q;
    assign sample_valid   = valid_q;
    assign busy_o         = busy_q;
    assign tmo_err        = tmo_q;

endmodule

// File: tb/tb_ads_conv_ctrl.sv
// Bench for ads_conv_ctrl: two instances (16-bit/half 2 and 8-bit/half 1),
// a behavioural converter model per instance and a data scoreboard.
module tb_ads_conv_ctrl;

    logic clk;
    logic rst_n;
    logic start_a;
    logic start_b;
    logic [15:0] data_a;
    logic [7:0]  data_b;
    logic valid_a, valid_b, busy_a, busy_b, tmo_a, tmo_b;

    ads_conv_ctrl_if bus_a ();
    ads_conv_ctrl_if bus_b ();

    ads_conv_ctrl #(
        .DATA_W(16), .SCLK_HALF(2), .CONVST_W(4), .TMO_CYC(32)
    ) u_dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start_a), .ads(bus_a),
        .sample_data(data_a), .sample_valid(valid_a), .busy_o(busy_a), .tmo_err(tmo_a)
    );

    ads_conv_ctrl #(
        .DATA_W(8), .SCLK_HALF(1), .CONVST_W(4), .TMO_CYC(32)
    ) u_dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start_b), .ads(bus_b),
        .sample_data(data_b), .sample_valid(valid_b), .busy_o(busy_b), .tmo_err(tmo_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Pin views indexed by instance.
    logic convst_s[2], cs_n_s[2], sclk_s[2], valid_s[2], tmo_s[2];
    logic drdy_n_m[2] = '{1'b1, 1'b1};
    logic dout_m[2]   = '{1'b0, 1'b0};

    assign convst_s[0] = bus_a.ads_convst;
    assign convst_s[1] = bus_b.ads_convst;
    assign cs_n_s[0]   = bus_a.ads_cs_n;
    assign cs_n_s[1]   = bus_b.ads_cs_n;
    assign sclk_s[0]   = bus_a.ads_sclk;
    assign sclk_s[1]   = bus_b.ads_sclk;
    assign valid_s[0]  = valid_a;
    assign valid_s[1]  = valid_b;
    assign tmo_s[0]    = tmo_a;
    assign tmo_s[1]    = tmo_b;
    assign bus_a.ads_drdy_n = drdy_n_m[0];
    assign bus_b.ads_drdy_n = drdy_n_m[1];
    assign bus_a.ads_dout   = dout_m[0];
    assign bus_b.ads_dout   = dout_m[1];

    // Converter model state.
    int          dly[2]    = '{20, 3};
    int          dcnt[2]   = '{0, 0};
    int          dw[2]     = '{16, 8};
    int          bitpos[2] = '{0, 0};
    logic [15:0] word[2]   = '{16'h0, 16'h0};
    logic [15:0] src_a[$];
    logic [15:0] src_b[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    // Monitor statistics.
    int convst_cnt[2], convst_rise[2], convst_fall[2], gap[2];
    int cs_cnt[2], cs_fall[2];
    int sclk_cnt[2], sclk_first[2], sclk_last[2];
    int valid_cnt[2], valid_cyc[2], tmo_cnt[2], tmo_cyc[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pop_src(input int i);
        logic [15:0] w;
        w = 16'h0;
        if (i == 0 && src_a.size() != 0) w = src_a.pop_front();
        if (i == 1 && src_b.size() != 0) w = src_b.pop_front();
        return w;
    endfunction

    function automatic int get_cnt(input int kind, input int i);
        case (kind)
            0:       return valid_cnt[i];
            1:       return tmo_cnt[i];
            2:       return convst_cnt[i];
            3:       return sclk_cnt[i];
            default: return cs_cnt[i];
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Bounded wait on a monitor counter; an expired budget is a failed check.
    task automatic wait_for(input string tag, input int kind, input int i, input int target,
                            input int budget);
        int n;
        n = 0;
        while (get_cnt(kind, i) < target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, (get_cnt(kind, i) >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            convst_cnt[i] = 0; convst_rise[i] = 0; convst_fall[i] = 0; gap[i] = 0;
            cs_cnt[i] = 0; cs_fall[i] = 0;
            sclk_cnt[i] = 0; sclk_first[i] = 0; sclk_last[i] = 0;
            valid_cnt[i] = 0; valid_cyc[i] = 0; tmo_cnt[i] = 0; tmo_cyc[i] = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Converter model: DRDY low dly cycles after CONVST falls, released when CS falls;
    // DOUT shows the MSB at CS fall and advances after each SCLK rise.
    initial begin : model
        logic pc[2], pcs[2], psc[2];
        pc = '{1'b0, 1'b0}; pcs = '{1'b1, 1'b1}; psc = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pc[i] && !convst_s[i] && dly[i] >= 0) begin
                    dcnt[i] = dly[i];
                end else if (dcnt[i] > 0) begin
                    dcnt[i]--;
                    if (dcnt[i] == 0) drdy_n_m[i] = 1'b0;
                end
                if (pcs[i] && !cs_n_s[i]) begin
                    drdy_n_m[i] = 1'b1;
                    word[i]     = pop_src(i);
                    bitpos[i]   = dw[i] - 1;
                    dout_m[i]   = word[i][bitpos[i]];
                end else if (!cs_n_s[i] && sclk_s[i] && !psc[i]) begin
                    bitpos[i]--;
                    dout_m[i] = (bitpos[i] >= 0) ? word[i][bitpos[i]] : 1'b0;
                end
                pc[i] = convst_s[i]; pcs[i] = cs_n_s[i]; psc[i] = sclk_s[i];
            end
        end
    end

    // Edge monitor and data scoreboard.
    initial begin : monitor
        logic pc[2], pcs[2], psc[2];
        logic [15:0] e;
        pc = '{1'b0, 1'b0}; pcs = '{1'b1, 1'b1}; psc = '{1'b0, 1'b0};
        clear_stats();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (convst_s[i] && !pc[i]) begin
                    convst_cnt[i]++; convst_rise[i] = cyc; gap[i] = cyc - valid_cyc[i];
                end
                if (!convst_s[i] && pc[i]) convst_fall[i] = cyc;
                if (!cs_n_s[i] && pcs[i]) begin
                    cs_cnt[i]++; cs_fall[i] = cyc;
                end
                if (sclk_s[i] && !psc[i]) begin
                    if (sclk_cnt[i] == 0) sclk_first[i] = cyc;
                    sclk_cnt[i]++; sclk_last[i] = cyc;
                end
                if (valid_s[i]) begin
                    valid_cnt[i]++; valid_cyc[i] = cyc;
                end
                if (tmo_s[i]) begin
                    tmo_cnt[i]++; tmo_cyc[i] = cyc;
                end
                pc[i] = convst_s[i]; pcs[i] = cs_n_s[i]; psc[i] = sclk_s[i];
            end
            if (valid_a) begin
                if (exp_a.size() != 0) e = exp_a.pop_front();
                else e = 16'hxxxx;
                check("sb_data_a", {16'h0, data_a}, {16'h0, e});
            end
            if (valid_b) begin
                if (exp_b.size() != 0) e = exp_b.pop_front();
                else e = 16'hxxxx;
                check("sb_data_b", {24'h0, data_b}, {16'h0, e});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        step(3);

        // Reset state.
        check("rst_convst", convst_s[0], 1'b0);
        check("rst_cs_n", cs_n_s[0], 1'b1);
        check("rst_sclk", sclk_s[0], 1'b0);
        check("rst_data", data_a, 16'h0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_tmo", tmo_a, 1'b0);
        check("rst_b_cs_n", cs_n_s[1], 1'b1);
        rst_n = 1'b1;
        step(2);

        // Nominal conversion.
        clear_stats();
        dly[0] = 20;
        src_a.push_back(16'hA5C3); exp_a.push_back(16'hA5C3);
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_for("nom_valid_seen", 0, 0, 1, 300);
        check("nom_convst_width", convst_fall[0] - convst_rise[0], 4);
        check("nom_sclk_rises", sclk_cnt[0], 16);
        check("nom_sclk_span", sclk_last[0] - sclk_first[0], 60);
        check("nom_done_latency", valid_cyc[0] - cs_fall[0], 64);
        step(1);
        check("nom_cs_n_after", cs_n_s[0], 1'b1);
        check("nom_busy_after", busy_a, 1'b0);
        check("nom_valid_pulse", valid_a, 1'b0);

        // DRDY timeout.
        clear_stats();
        dly[0] = -1;
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_for("tmo_seen", 1, 0, 1, 200);
        check("tmo_delay", tmo_cyc[0] - convst_fall[0], 32);
        check("tmo_data_kept", data_a, 16'hA5C3);
        check("tmo_no_sclk", sclk_cnt[0], 0);
        check("tmo_no_cs", cs_cnt[0], 0);
        step(1);
        check("tmo_busy_drop", busy_a, 1'b0);
        check("tmo_pulse", tmo_a, 1'b0);

        // start during SHIFT is ignored.
        clear_stats();
        dly[0] = 5;
        src_a.push_back(16'h5A5A); exp_a.push_back(16'h5A5A);
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_for("ign_shift_seen", 4, 0, 1, 200);
        step(3);
        start_a = 1'b1; step(2); start_a = 1'b0;
        wait_for("ign_valid_seen", 0, 0, 1, 300);
        step(10);
        check("ign_convst_cnt", convst_cnt[0], 1);
        check("ign_valid_cnt", valid_cnt[0], 1);

        // Back-to-back with start held high.
        clear_stats();
        dly[0] = 20;
        src_a.push_back(16'h0001); exp_a.push_back(16'h0001);
        src_a.push_back(16'hFFFF); exp_a.push_back(16'hFFFF);
        start_a = 1'b1;
        wait_for("b2b_second_conv", 2, 0, 2, 400);
        start_a = 1'b0;
        wait_for("b2b_second_valid", 0, 0, 2, 400);
        step(5);
        check("b2b_valid_cnt", valid_cnt[0], 2);
        check("b2b_convst_cnt", convst_cnt[0], 2);
        check("b2b_restart_gap", gap[0], 2);

        // Reset in the middle of the shift.
        clear_stats();
        dly[0] = 20;
        src_a.push_back(16'hDEAD);
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_for("rst_bit7_seen", 3, 0, 8, 400);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", cs_n_s[0], 1'b1);
        check("mid_rst_sclk", sclk_s[0], 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_data", data_a, 16'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("mid_rst_no_valid", valid_cnt[0], 0);
        clear_stats();
        src_a.push_back(16'h1234); exp_a.push_back(16'h1234);
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_for("post_rst_valid", 0, 0, 1, 300);
        step(2);
        check("post_rst_valid_cnt", valid_cnt[0], 1);

        // Minimum divider, 8-bit sample.
        clear_stats();
        dly[1] = 3;
        src_b.push_back(16'h0080); exp_b.push_back(16'h0080);
        start_b = 1'b1; step(1); start_b = 1'b0;
        wait_for("bnd_valid_seen", 0, 1, 1, 300);
        check("bnd_sclk_rises", sclk_cnt[1], 8);
        check("bnd_sclk_span", sclk_last[1] - sclk_first[1], 14);
        check("bnd_done_latency", valid_cyc[1] - cs_fall[1], 16);
        step(1);
        check("bnd_cs_n_after", cs_n_s[1], 1'b1);
        check("bnd_a_quiet", valid_cnt[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
